// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: opcode encodings, default
// data width and the packed result-entry layout.
package alu_pkg;

    localparam int ALU_WIDTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NOT = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LT  = 3'b110;
    localparam logic [2:0] OP_EQ  = 3'b111;

    // One captured ALU result at the default width; field order matches the
    // bit packing used by alu_result_pipe for its storage words.
    typedef struct packed {
        logic [2:0]           op;
        logic [ALU_WIDTH-1:0] f;
        logic                 zero;
        logic                 over;
        logic                 cout;
        logic                 less;
    } alu_res_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Small synchronous FIFO: storage array, read/write pointers and occupancy
// count. The head word is read combinationally so a write into an empty FIFO
// is visible right after the writing edge. Pointers wrap naturally because
// DEPTH is a power of two.
module alu_res_fifo #(
    parameter int DW    = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DW-1:0]            wr_data,
    input  logic                     rd_en,
    output logic [DW-1:0]            rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and count update; simultaneous read and write leave count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (rd_en && !wr_en) begin
            count_d = count_q - CW'(1);
        end
    end

    // Control state; stored data is left untouched by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/alu_result_pipe.sv
// Registered stage behind the combinational ALU. Buffers results with their
// flags and opcode in alu_res_fifo, hands them out over valid/ready, and keeps
// sticky overflow/carry status for arithmetic opcodes.
// Optional consistency checker enabled with macro ALU_RES_CHECK_EN.
module alu_result_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_f,
    input  logic                     in_zero,
    input  logic                     in_over,
    input  logic                     in_cout,
    input  logic                     in_less,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2:0]               out_op,
    output logic [WIDTH-1:0]         out_f,
    output logic                     out_zero,
    output logic                     out_over,
    output logic                     out_cout,
    output logic                     out_less,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sticky_over,
    output logic                     sticky_cout,
    input  logic                     clr_sticky,
    output logic                     chk_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int DW = WIDTH + 7;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DW-1:0] wr_word;
    logic [DW-1:0] head_word;
    logic [CW-1:0] count_w;
    logic          push;
    logic          pop;
    logic          arith_op;

    logic          rdy_en_q, rdy_en_d;
    logic          sticky_over_q, sticky_over_d;
    logic          sticky_cout_q, sticky_cout_d;

    // in_ready stays low in reset and for the edge that releases it.
    assign in_ready  = rdy_en_q && (count_w != FULL);
    assign out_valid = (count_w != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign arith_op  = (in_op == OP_ADD) || (in_op == OP_SUB);

    assign wr_word = {in_op, in_f, in_zero, in_over, in_cout, in_less};

    alu_res_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_word),
        .rd_en   (pop),
        .rd_data (head_word),
        .count   (count_w)
    );

    // Head fields forced to zero when empty so outputs read 0 after reset.
    always_comb begin
        out_op   = '0;
        out_f    = '0;
        out_zero = 1'b0;
        out_over = 1'b0;
        out_cout = 1'b0;
        out_less = 1'b0;
        if (out_valid) begin
            {out_op, out_f, out_zero, out_over, out_cout, out_less} = head_word;
        end
    end

    // Sticky status: clear first, then a setting push overrides the clear.
    always_comb begin
        rdy_en_d      = 1'b1;
        sticky_over_d = clr_sticky ? 1'b0 : sticky_over_q;
        sticky_cout_d = clr_sticky ? 1'b0 : sticky_cout_q;
        if (push && arith_op && in_over) begin
            sticky_over_d = 1'b1;
        end
        if (push && arith_op && in_cout) begin
            sticky_cout_d = 1'b1;
        end
    end

    // Status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q      <= 1'b0;
            sticky_over_q <= 1'b0;
            sticky_cout_q <= 1'b0;
        end else begin
            rdy_en_q      <= rdy_en_d;
            sticky_over_q <= sticky_over_d;
            sticky_cout_q <= sticky_cout_d;
        end
    end

    assign count       = count_w;
    assign sticky_over = sticky_over_q;
    assign sticky_cout = sticky_cout_q;

`ifdef ALU_RES_CHECK_EN
    logic chk_err_q, chk_err_d;

    // Flag-consistency check on every push; only reset clears the error.
    always_comb begin
        chk_err_d = chk_err_q;
        if (push) begin
            if (in_zero != (in_f == '0)) begin
                chk_err_d = 1'b1;
            end
            if (((in_op == OP_LT) || (in_op == OP_EQ)) &&
                (in_f != {{(WIDTH-1){1'b0}}, in_less})) begin
                chk_err_d = 1'b1;
            end
        end
    end

    // Error latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else begin
            chk_err_q <= chk_err_d;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_pipe.sv
// Scoreboard bench for alu_result_pipe: the stimulus process queues each
// accepted entry; a negedge monitor compares the DUT head against the queue.
module tb_alu_result_pipe;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'b0;
    logic [3:0] in_f = 4'h0;
    logic       in_zero = 1'b0;
    logic       in_over = 1'b0;
    logic       in_cout = 1'b0;
    logic       in_less = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_op;
    logic [3:0] out_f;
    logic       out_zero, out_over, out_cout, out_less;
    logic [2:0] count;
    logic       sticky_over, sticky_cout;
    logic       clr_sticky = 1'b0;
    logic       chk_err;

    int vectors = 0;
    int miscompares = 0;
    alu_res_t sb[$];

    alu_result_pipe #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_f(in_f),
        .in_zero(in_zero), .in_over(in_over), .in_cout(in_cout), .in_less(in_less),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_f(out_f),
        .out_zero(out_zero), .out_over(out_over), .out_cout(out_cout), .out_less(out_less),
        .count(count),
        .sticky_over(sticky_over), .sticky_cout(sticky_cout),
        .clr_sticky(clr_sticky), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one entry for one edge; queue it only if the DUT accepted it.
    task automatic do_push(input logic [2:0] op, input logic [3:0] f,
                           input logic z, input logic o, input logic c,
                           input logic l, input logic clr);
        alu_res_t e;
        logic acc;
        in_valid = 1'b1; in_op = op; in_f = f;
        in_zero = z; in_over = o; in_cout = c; in_less = l;
        clr_sticky = clr;
        e = '{op: op, f: f, zero: z, over: o, cout: c, less: l};
        acc = in_ready;
        step();
        if (acc) sb.push_back(e);
        $display("push op=%0d f=%h accepted=%0b", op, f, acc);
        in_valid = 1'b0; in_over = 1'b0; in_cout = 1'b0; clr_sticky = 1'b0;
    endtask

    // Monitor: every valid head is compared; a pop retires the entry.
    always @(negedge clk) begin
        alu_res_t got;
        alu_res_t exp;
        if (rst_n) begin
            got = '{op: out_op, f: out_f, zero: out_zero, over: out_over,
                    cout: out_cout, less: out_less};
            if (out_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL head_unexpected: got %h expected none", got);
                end else begin
                    exp = sb[0];
                    if (got != exp) begin
                        miscompares++;
                        $display("FAIL head: got %h expected %h", got, exp);
                    end else if (out_ready) begin
                        $display("pop  op=%0d f=%h ok", got.op, got.f);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end else if (sb.size() != 0) begin
                vectors++;
                miscompares++;
                $display("FAIL head_missing: got out_valid=0 expected %0d entries", sb.size());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count", int'(count), 0);
        check("rst_chk_err", int'(chk_err), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        step();
        check("post_rst_in_ready", int'(in_ready), 1);
        check("post_rst_sticky_over", int'(sticky_over), 0);

        // Single ADD 7+1, consumer ready
        out_ready = 1'b1;
        do_push(OP_ADD, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t1_out_valid", int'(out_valid), 1);
        check("t1_out_f", int'(out_f), 8);
        check("t1_out_over", int'(out_over), 1);
        check("t1_sticky_over", int'(sticky_over), 1);
        check("t1_sticky_cout", int'(sticky_cout), 0);
        step();
        check("t1_count", int'(count), 0);

        // Fill to full with consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++)
            do_push(OP_OR, 4'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_in_ready_full", int'(in_ready), 0);
        check("t2_count_full", int'(count), 4);
        do_push(OP_OR, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t2_count_blocked", int'(count), 4);
        out_ready = 1'b1;
        step();
        check("t2_in_ready_after_pop", int'(in_ready), 1);
        check("t2_count_after_pop", int'(count), 3);
        repeat (3) step();
        check("t2_count_drained", int'(count), 0);

        // Simultaneous push/pop at count 2, wrapping pointers
        out_ready = 1'b0;
        do_push(OP_XOR, 4'hE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_push(OP_XOR, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3_count_pre", int'(count), 2);
        out_ready = 1'b1;
        for (int v = 5; v <= 10; v++) begin
            do_push(OP_OR, 4'(v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check("t3_count_steady", int'(count), 2);
        end
        repeat (2) step();
        check("t3_count_drained", int'(count), 0);

        // Sticky behaviour
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("t4_clr_over", int'(sticky_over), 0);
        check("t4_clr_cout", int'(sticky_cout), 0);
        do_push(OP_AND, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("t4_and_no_sticky", int'(sticky_over), 0);
        do_push(OP_SUB, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t4_set_wins", int'(sticky_cout), 1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("t4_clr_alone", int'(sticky_cout), 0);
        step();

        // Asynchronous reset with 3 entries stored
        out_ready = 1'b0;
        do_push(OP_ADD, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_push(OP_OR, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_push(OP_OR, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_count_pre", int'(count), 3);
        check("t5_sticky_cout_pre", int'(sticky_cout), 1);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        check("t5_rst_out_valid", int'(out_valid), 0);
        check("t5_rst_count", int'(count), 0);
        check("t5_rst_sticky_cout", int'(sticky_cout), 0);
        check("t5_rst_in_ready", int'(in_ready), 0);
        check("t5_rst_out_f", int'(out_f), 0);
        @(posedge clk); #3 rst_n = 1'b1;
        step();
        check("t5_post_in_ready", int'(in_ready), 1);
        check("t5_post_count", int'(count), 0);
        out_ready = 1'b1;
        do_push(OP_OR, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_latency1", int'(out_valid), 1);
        check("t5_out_f", int'(out_f), 9);
        step();

        // Flag-consistency checker
        do_push(OP_OR, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef ALU_RES_CHECK_EN
        check("t6_chk_err", int'(chk_err), 1);
`else
        check("t6_chk_err", int'(chk_err), 0);
`endif
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
`ifdef ALU_RES_CHECK_EN
        check("t6_chk_err_hold", int'(chk_err), 1);
`else
        check("t6_chk_err_hold", int'(chk_err), 0);
`endif
        step();
        check("t6_count_end", int'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
